// File: rtl/serial_add_accum_pkg.sv
// Shared types and helpers for the bit-serial adder stage.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count 0..w-1 accepted bits; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 3) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_accum_if.sv
// Operand/result bundle for serial_add_accum. The sub input exists only
// when SERIAL_ADD_SUB_EN is defined.
interface serial_add_accum_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    // Handshake: a_bit/b_bit are consumed on a rising edge where bit_valid=1 and
    // busy=1; there is no back-pressure, and start is sampled only while busy=0.
    logic             start;
    logic             bit_valid;
    logic             a_bit;
    logic             b_bit;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    state_t           dbg_state;

    modport master (
        output start, bit_valid, a_bit, b_bit,
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        input  busy, done, result, carry_out, dbg_state
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        output busy, done, result, carry_out, dbg_state
    );

endinterface

// File: rtl/serial_add_accum_fa_cell.sv
// Combinational full-add bit: two half-add stages whose carries are ORed.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic hs1_sum;
    logic hs1_carry;
    logic hs2_carry;

    assign hs1_sum   = a ^ b;
    assign hs1_carry = a & b;
    assign sum       = hs1_sum ^ cin;
    assign hs2_carry = hs1_sum & cin;
    assign cout      = hs1_carry | hs2_carry;

endmodule

// File: rtl/serial_add_accum.sv
// Bit-serial WIDTH-bit adder with carry register and result shift register.
// Define SERIAL_ADD_SUB_EN to add the sub input (A-B via inverted B, carry preset).
module serial_add_accum
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_accum_if.slave   bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             b_eff;
    logic             start_carry;
    logic             fa_sum;
    logic             fa_cout;

`ifdef SERIAL_ADD_SUB_EN
    logic             sub_q, sub_d;
    assign b_eff       = bus.b_bit ^ sub_q;
    assign start_carry = bus.sub;
`else
    assign b_eff       = bus.b_bit;
    assign start_carry = 1'b0;
`endif

    serial_fa_cell u_fa (
        .a    (bus.a_bit),
        .b    (b_eff),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub_d    = sub_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // A bit presented alongside start is deliberately not consumed.
                if (bus.start) begin
                    state_d  = SHIFT;
                    carry_d  = start_carry;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
                    sub_d    = bus.sub;
`endif
                end
            end
            SHIFT: begin
                if (bus.bit_valid) begin
                    carry_d  = fa_cout;
                    result_d = {fa_sum, result_q[WIDTH-1:1]};
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        cout_d  = fa_cout;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_ADD_SUB_EN
            sub_q    <= sub_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry_out = cout_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_accum.sv
// Self-checking bench for serial_add_accum: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_serial_add_accum;
    import serial_add_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_accum_if #(.WIDTH(W)) bus ();
    serial_add_accum #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    logic [W:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: {carry_out, result} as plain (W+1)-bit arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
        logic [W:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

    task automatic drive_idle();
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.a_bit     = 1'b0;
        bus.b_bit     = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub       = 1'b0;
`endif
    endtask

    // Start an operation; a junk bit is offered with start and must be ignored.
    task automatic issue_start(input logic sub);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.bit_valid = 1'b1;
        bus.a_bit     = 1'b1;
        bus.b_bit     = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub       = sub;
`else
        if (sub) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
        @(negedge clk);
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int max_gap,
                          input int restart_at, input logic sub);
        logic [W:0] exp;
        exp_q.push_back(model(a, b, sub));
        issue_start(sub);
        for (int i = 0; i < W; i++) begin
            int gaps;
            gaps = $urandom_range(max_gap, 0);
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                check("busy_in_gap", 32'(bus.busy), 32'd1);
            end
            bus.a_bit     = a[i];
            bus.b_bit     = b[i];
            bus.bit_valid = 1'b1;
            bus.start     = (i == restart_at);
            @(negedge clk);
            bus.bit_valid = 1'b0;
            bus.start     = 1'b0;
            if (i < W - 1) check("done_early", 32'(bus.done), 32'd0);
        end
        exp = exp_q.pop_front();
        check("done_pulse", 32'(bus.done), 32'd1);
        check("busy_cleared", 32'(bus.busy), 32'd0);
        check("result", 32'(bus.result), 32'(exp[W-1:0]));
        check("carry_out", 32'(bus.carry_out), 32'(exp[W]));
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("result_held", 32'(bus.result), 32'(exp[W-1:0]));
        check("carry_held", 32'(bus.carry_out), 32'(exp[W]));
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        #3;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_carry", 32'(bus.carry_out), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        // bit_valid alone in IDLE must not start anything.
        bus.bit_valid = 1'b1;
        bus.a_bit     = 1'b1;
        @(negedge clk);
        bus.bit_valid = 1'b0;
        check("idle_ignores_bits", 32'(bus.busy), 32'd0);

        run_op(8'h35, 8'h4A, 0, -1, 1'b0);
        run_op(8'hFF, 8'h01, 0, -1, 1'b0);
        run_op(8'h35, 8'h4A, 5, -1, 1'b0);
        run_op(8'h12, 8'h34, 0, 3, 1'b0);

        // DONE holds without start.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("done_stays_low", 32'(bus.done), 32'd0);
            check("done_hold_result", 32'(bus.result), 32'h46);
        end

        // Asynchronous reset mid-operation.
        issue_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.a_bit     = 1'b1;
            bus.b_bit     = 1'b0;
            bus.bit_valid = 1'b1;
            @(negedge clk);
        end
        bus.bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_result", 32'(bus.result), 32'd0);
        check("arst_carry", 32'(bus.carry_out), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_state", 32'(bus.dbg_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h01, 8'h01, 0, -1, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 0, -1, 1'b1);
        run_op(8'h01, 8'h02, 2, -1, 1'b1);
`endif

        for (int n = 0; n < 20; n++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom_range(1, 0));
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, 3, int'($urandom_range(W + 2, 0)), rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
